// File: rtl/npu_pkg.sv
// Shared NPU definitions: feature-map geometry, quantization modes,
// requant FSM states and integer saturation bounds.
package npu_pkg;
  localparam int VALID_CORE_NUM = 15;
  localparam int FMS_PATCH_SIZE = 8;
  localparam int IN_WIDTH       = 20;
  localparam int OUT_WIDTH      = 8;
  localparam int SHIFT_WIDTH    = 5;
  localparam int NUM_LANES      = FMS_PATCH_SIZE * FMS_PATCH_SIZE;

  typedef enum logic {
    QM_INT4 = 1'b0,
    QM_INT8 = 1'b1
  } quant_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROC  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;
  localparam int INT4_MIN = -8;
  localparam int INT4_MAX = 7;
endpackage

// File: rtl/requant_lane.sv
// One lane of requantization: rounding arithmetic right shift, optional
// ReLU, then saturation to INT4/INT8 (INT4 sign-extended to OUT_WIDTH).
module requant_lane #(
  parameter int IN_WIDTH    = npu_pkg::IN_WIDTH,
  parameter int OUT_WIDTH   = npu_pkg::OUT_WIDTH,
  parameter int SHIFT_WIDTH = npu_pkg::SHIFT_WIDTH
) (
  input  logic signed [IN_WIDTH-1:0]    x,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                          relu,
  input  npu_pkg::quant_mode_e          mode,
  output logic        [OUT_WIDTH-1:0]   y,
  output logic                          sat
);
  import npu_pkg::*;

  // One guard bit so x + rounding bias can never wrap.
  localparam int EW = IN_WIDTH + 1;

  logic        [SHIFT_WIDTH-1:0] sh;
  logic signed [EW-1:0]          xe, bias, rnd, v, lo, hi;

  // Round-half-up shift, ReLU and clamp, all in the widened domain.
  always_comb begin
    // Shifting further than IN_WIDTH-1 would only yield 0/-1; pin it there.
    sh   = (shift > SHIFT_WIDTH'(IN_WIDTH - 1)) ? SHIFT_WIDTH'(IN_WIDTH - 1) : shift;
    xe   = EW'(x);
    bias = '0;
    if (sh != '0) bias = EW'(1) <<< (sh - 1'b1);
    rnd  = xe + bias;
    v    = rnd >>> sh;
    if (relu && v[EW-1]) v = '0;
    hi   = (mode == QM_INT8) ? EW'(INT8_MAX) : EW'(INT4_MAX);
    lo   = (mode == QM_INT8) ? EW'(INT8_MIN) : EW'(INT4_MIN);
    sat  = 1'b0;
    y    = v[OUT_WIDTH-1:0];
    if (v > hi) begin
      y   = hi[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (v < lo) begin
      y   = lo[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/infms_requant_unit.sv
// Captures one channel-summed feature-map word and streams it out one core
// per beat, requantized to 8-bit lanes, over a valid/ready handshake.
module infms_requant_unit #(
  parameter int VALID_CORE_NUM = npu_pkg::VALID_CORE_NUM,
  parameter int FMS_PATCH_SIZE = npu_pkg::FMS_PATCH_SIZE,
  parameter int IN_WIDTH       = npu_pkg::IN_WIDTH,
  parameter int OUT_WIDTH      = npu_pkg::OUT_WIDTH,
  parameter int SHIFT_WIDTH    = npu_pkg::SHIFT_WIDTH
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          clk_en,
  input  logic                                                          infms_data_vld,
  input  logic [VALID_CORE_NUM*FMS_PATCH_SIZE*FMS_PATCH_SIZE*IN_WIDTH-1:0] infms_data,
  input  logic                                                          quant_mode,
  input  logic [SHIFT_WIDTH-1:0]                                        shift_amt,
  input  logic                                                          relu_en,
  output logic                                                          in_ready,
  output logic                                                          out_vld,
  input  logic                                                          out_ready,
  output logic [FMS_PATCH_SIZE*FMS_PATCH_SIZE*OUT_WIDTH-1:0]            out_data,
  output logic [3:0]                                                    out_core_idx,
  output logic                                                          out_last,
  output logic                                                          sat_flag,
  output logic                                                          drop_err
);
  import npu_pkg::*;

  localparam int          NUM_LANES = FMS_PATCH_SIZE * FMS_PATCH_SIZE;
  localparam int          CORE_W    = NUM_LANES * IN_WIDTH;
  localparam logic [3:0]  LAST_CORE = 4'(VALID_CORE_NUM - 1);

  state_e                                state_q;
  logic [VALID_CORE_NUM*CORE_W-1:0]      buf_q;
  quant_mode_e                           mode_q;
  logic [SHIFT_WIDTH-1:0]                shift_q;
  logic                                  relu_q;
  logic [3:0]                            k_q;

  logic [CORE_W-1:0]                     core_word;
  logic [NUM_LANES-1:0][OUT_WIDTH-1:0]   lane_y;
  logic [NUM_LANES-1:0]                  lane_sat;

  wire capture = clk_en && (state_q == ST_IDLE) && infms_data_vld;
  wire load    = (state_q == ST_PROC) && (!out_vld || out_ready);

  // Core k of the captured word feeds the lane array.
  assign core_word = buf_q[k_q*CORE_W +: CORE_W];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    requant_lane #(
      .IN_WIDTH   (IN_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .x    (core_word[l*IN_WIDTH +: IN_WIDTH]),
      .shift(shift_q),
      .relu (relu_q),
      .mode (mode_q),
      .y    (lane_y[l]),
      .sat  (lane_sat[l])
    );
  end

  // Capture buffer and per-frame settings; contents are don't-care until a
  // capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q   <= infms_data;
      mode_q  <= quant_mode_e'(quant_mode);
      shift_q <= shift_amt;
      relu_q  <= relu_en;
    end
  end

  // Frame FSM: IDLE accepts a word, PROC loads one core per accepted slot,
  // DRAIN waits for the final beat to be taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready     <= 1'b1;
      out_vld      <= 1'b0;
      out_data     <= '0;
      out_core_idx <= '0;
      out_last     <= 1'b0;
      sat_flag     <= 1'b0;
      drop_err     <= 1'b0;
      k_q          <= '0;
    end else if (clk_en) begin
      if (infms_data_vld && state_q != ST_IDLE) drop_err <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (infms_data_vld) begin
            sat_flag <= 1'b0;
            k_q      <= '0;
            in_ready <= 1'b0;
            state_q  <= ST_PROC;
          end
        end
        ST_PROC: begin
          if (load) begin
            out_vld      <= 1'b1;
            out_data     <= lane_y;
            out_core_idx <= k_q;
            out_last     <= (k_q == LAST_CORE);
            sat_flag     <= sat_flag | (|lane_sat);
            k_q          <= k_q + 4'd1;
            if (k_q == LAST_CORE) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_vld && out_ready) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            in_ready <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_infms_requant_unit.sv
// Self-checking bench for infms_requant_unit: randomized words checked
// against an arithmetic reference of the requantization rules.
module tb_infms_requant_unit;
  localparam int NC = 15, NL = 64, IW = 20, OW = 8;
  localparam int WW = NC * NL * IW, DW = NL * OW;
  typedef int word_t [NC][NL];

  logic          clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
  logic          infms_data_vld = 1'b0, quant_mode = 1'b0, relu_en = 1'b0, out_ready = 1'b1;
  logic [WW-1:0] infms_data = '0;
  logic [4:0]    shift_amt = '0;
  logic          in_ready, out_vld, out_last, sat_flag, drop_err;
  logic [DW-1:0] out_data;
  logic [3:0]    out_core_idx;

  int checks = 0, errors = 0;

  logic [DW-1:0] q_data[$];
  int            q_idx[$];
  bit            q_last[$];
  bit            q_sat[$];

  always #5 clk = ~clk;

  infms_requant_unit dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .infms_data_vld(infms_data_vld), .infms_data(infms_data),
    .quant_mode(quant_mode), .shift_amt(shift_amt), .relu_en(relu_en),
    .in_ready(in_ready), .out_vld(out_vld), .out_ready(out_ready),
    .out_data(out_data), .out_core_idx(out_core_idx), .out_last(out_last),
    .sat_flag(sat_flag), .drop_err(drop_err)
  );

  // Beat monitor: a beat is transferred at the next rising edge.
  always @(negedge clk) begin
    if (!rst && clk_en && out_vld && out_ready) begin
      q_data.push_back(out_data);
      q_idx.push_back(int'(out_core_idx));
      q_last.push_back(out_last);
      q_sat.push_back(sat_flag);
    end
  end

  // Reference: round half up by floor((x + d/2) / d), ReLU, clamp.
  function automatic logic [7:0] ref_lane(input int x, input int sh_in, input bit r, input bit m, output bit s);
    longint num, d, y, lo, hi;
    int sh;
    sh = (sh_in > 19) ? 19 : sh_in;
    y  = longint'(x);
    if (sh > 0) begin
      d   = longint'(1) << sh;
      num = longint'(x) + d / 2;
      y   = num / d;
      if (num < 0 && (num % d) != 0) y = y - 1;
    end
    if (r && y < 0) y = 0;
    hi = m ? 127 : 7;
    lo = m ? -128 : -8;
    s  = 0;
    if (y > hi) begin y = hi; s = 1; end
    else if (y < lo) begin y = lo; s = 1; end
    return y[7:0];
  endfunction

  function automatic logic [DW-1:0] exp_core(input word_t v, input int c, input bit m, input int sh, input bit r, output bit s);
    logic [DW-1:0] d;
    bit ls;
    d = '0;
    s = 0;
    for (int l = 0; l < NL; l++) begin
      d[l*OW +: OW] = ref_lane(v[c][l], sh, r, m, ls);
      s |= ls;
    end
    return d;
  endfunction

  function automatic word_t rand_word(input int mag);
    word_t v;
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NL; l++)
        v[c][l] = int'($urandom_range(0, 2 * mag - 1)) - mag;
    return v;
  endfunction

  task automatic drive_word(input word_t v);
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NL; l++)
        infms_data[(c*NL+l)*IW +: IW] = v[c][l][IW-1:0];
  endtask

  // Strobe one word; returns just after the capturing edge. Settings and
  // data are scrambled afterwards so only captured values may matter.
  task automatic start_frame(input word_t v, input bit m, input int sh, input bit r);
    @(posedge clk); #1;
    drive_word(v);
    quant_mode = m; shift_amt = 5'(sh); relu_en = r; infms_data_vld = 1'b1;
    @(posedge clk); #1;
    infms_data_vld = 1'b0;
    quant_mode = ~m; shift_amt = 5'($urandom); relu_en = ~r;
    infms_data = ~infms_data;
  endtask

  // Wait for 15 recorded beats (bounded), optionally toggling out_ready.
  task automatic wait_frame(input bit rnd, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (q_data.size() >= NC) begin ok = 1; break; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic void clear_q();
    q_data.delete(); q_idx.delete(); q_last.delete(); q_sat.delete();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset out_vld: got %b want 0", out_vld); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset out_data: got %h want 0", out_data); end
    checks++; if (out_core_idx !== 4'd0) begin errors++; $display("FAIL reset out_core_idx: got %0d want 0", out_core_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset out_last: got %b want 0", out_last); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset sat_flag: got %b want 0", sat_flag); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset drop_err: got %b want 0", drop_err); end
  endtask

  task automatic test_int8_basic();
    word_t v;
    logic [DW-1:0] want;
    for (int c = 0; c < NC; c++) for (int l = 0; l < NL; l++) v[c][l] = 256;
    want = {NL{8'h10}};
    clear_q(); out_ready = 1'b1;
    start_frame(v, 1'b1, 4, 1'b0);
    @(negedge clk);
    checks++; if (out_vld !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL basic after N: got vld=%b rdy=%b want vld=0 rdy=0", out_vld, in_ready); end
    @(posedge clk); #1;
    checks++; if (out_vld !== 1'b1 || out_core_idx !== 4'd0) begin errors++; $display("FAIL basic N+1: got vld=%b idx=%0d want vld=1 idx=0", out_vld, out_core_idx); end
    repeat (14) @(posedge clk);
    #1;
    checks++; if (out_vld !== 1'b1 || out_last !== 1'b1 || out_core_idx !== 4'd14) begin errors++; $display("FAIL basic N+15: got vld=%b last=%b idx=%0d want 1 1 14", out_vld, out_last, out_core_idx); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_vld !== 1'b0) begin errors++; $display("FAIL basic N+16: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_vld); end
    checks++; if (q_data.size() != NC) begin errors++; $display("FAIL basic beats: got %0d want %0d", q_data.size(), NC); end
    for (int c = 0; c < NC && c < q_data.size(); c++) begin
      checks++;
      if (q_data[c] !== want || q_idx[c] !== c || q_last[c] !== (c == NC - 1)) begin
        errors++; $display("FAIL basic beat %0d: got idx=%0d last=%0b data=%h want idx=%0d data=%h", c, q_idx[c], q_last[c], q_data[c], c, want);
      end
    end
    checks++; if (q_sat.size() == NC && q_sat[NC-1] !== 1'b0) begin errors++; $display("FAIL basic sat_flag: got 1 want 0"); end
  endtask

  task automatic test_int4_sat();
    word_t v;
    logic [DW-1:0] want;
    bit ok;
    for (int c = 0; c < NC; c++) for (int l = 0; l < NL; l++) v[c][l] = (l % 2 == 0) ? 100 : -100;
    want = {(NL/2){8'hF8, 8'h07}};
    clear_q();
    start_frame(v, 1'b0, 0, 1'b0);
    wait_frame(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL int4 timeout: got %0d beats want %0d", q_data.size(), NC); end
    for (int c = 0; c < NC && c < q_data.size(); c++) begin
      checks++;
      if (q_data[c] !== want || q_idx[c] !== c) begin
        errors++; $display("FAIL int4 beat %0d: got idx=%0d data=%h want data=%h", c, q_idx[c], q_data[c], want);
      end
    end
    checks++; if (q_sat.size() != NC || q_sat[NC-1] !== 1'b1) begin errors++; $display("FAIL int4 sat_flag: got 0 want 1"); end
  endtask

  task automatic test_rounding(input bit r);
    int tbl[16] = '{6, -6, 2, -2, 5, -5, 7, -7, 1, -1, 3, -3, 524287, -524288, 0, 509};
    word_t v;
    logic [DW-1:0] exp;
    bit ok, s, es;
    for (int c = 0; c < NC; c++) for (int l = 0; l < NL; l++) v[c][l] = tbl[l % 16];
    clear_q();
    start_frame(v, 1'b1, 2, r);
    wait_frame(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL round timeout relu=%0b: got %0d beats", r, q_data.size()); end
    if (q_data.size() > 0) begin
      checks++;
      if (q_data[0][7:0] !== 8'd2 || q_data[0][15:8] !== (r ? 8'h00 : 8'hFF)) begin
        errors++; $display("FAIL round lanes relu=%0b: got %h %h want 02 %h", r, q_data[0][7:0], q_data[0][15:8], r ? 8'h00 : 8'hFF);
      end
    end
    es = 0;
    for (int c = 0; c < NC && c < q_data.size(); c++) begin
      checks++;
      exp = exp_core(v, c, 1'b1, 2, r, s); es |= s;
      if (q_data[c] !== exp || q_idx[c] !== c) begin
        errors++; $display("FAIL round beat %0d relu=%0b: got idx=%0d data=%h want data=%h", c, r, q_idx[c], q_data[c], exp);
      end
    end
    checks++; if (q_sat.size() != NC || q_sat[NC-1] !== es) begin errors++; $display("FAIL round sat_flag relu=%0b: want %0b", r, es); end
  endtask

  task automatic test_backpressure();
    word_t v;
    logic [DW-1:0] exp;
    bit ok, s, found;
    int sh;
    v = rand_word(4096); sh = int'($urandom_range(3, 8));
    clear_q(); found = 0;
    start_frame(v, 1'b1, sh, 1'b0);
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_vld && out_core_idx == 4'd3) begin out_ready = 1'b0; found = 1; end
      else begin @(posedge clk); #1; end
    end
    checks++; if (!found) begin errors++; $display("FAIL bp core3 never presented"); end
    exp = exp_core(v, 3, 1'b1, sh, 1'b0, s);
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (out_vld !== 1'b1 || out_core_idx !== 4'd3 || out_data !== exp) begin
        errors++; $display("FAIL bp hold: got vld=%b idx=%0d data=%h want vld=1 idx=3 data=%h", out_vld, out_core_idx, out_data, exp);
      end
    end
    out_ready = 1'b1;
    wait_frame(1'b0, ok);
    checks++; if (!ok || q_data.size() != NC) begin errors++; $display("FAIL bp beats: got %0d want %0d", q_data.size(), NC); end
    for (int c = 0; c < NC && c < q_data.size(); c++) begin
      checks++;
      exp = exp_core(v, c, 1'b1, sh, 1'b0, s);
      if (q_data[c] !== exp || q_idx[c] !== c) begin
        errors++; $display("FAIL bp beat %0d: got idx=%0d data=%h want data=%h", c, q_idx[c], q_data[c], exp);
      end
    end
  endtask

  task automatic test_clk_en();
    word_t v;
    logic [DW-1:0] exp;
    bit ok, s, found;
    v = rand_word(2048);
    clear_q(); found = 0;
    start_frame(v, 1'b1, 5, 1'b1);
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_vld && out_core_idx == 4'd5) begin clk_en = 1'b0; found = 1; end
      else begin @(posedge clk); #1; end
    end
    checks++; if (!found) begin errors++; $display("FAIL clken core5 never presented"); end
    exp = exp_core(v, 5, 1'b1, 5, 1'b1, s);
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (out_vld !== 1'b1 || out_core_idx !== 4'd5 || out_data !== exp) begin
        errors++; $display("FAIL clken hold: got vld=%b idx=%0d data=%h want idx=5 data=%h", out_vld, out_core_idx, out_data, exp);
      end
    end
    checks++; if (q_data.size() != 5) begin errors++; $display("FAIL clken beats during hold: got %0d want 5", q_data.size()); end
    clk_en = 1'b1;
    wait_frame(1'b0, ok);
    checks++; if (!ok || q_data.size() != NC) begin errors++; $display("FAIL clken beats: got %0d want %0d", q_data.size(), NC); end
    for (int c = 0; c < NC && c < q_data.size(); c++) begin
      checks++;
      exp = exp_core(v, c, 1'b1, 5, 1'b1, s);
      if (q_data[c] !== exp || q_idx[c] !== c) begin
        errors++; $display("FAIL clken beat %0d: got idx=%0d data=%h want data=%h", c, q_idx[c], q_data[c], exp);
      end
    end
  endtask

  task automatic test_random();
    word_t v;
    logic [DW-1:0] exp;
    bit ok, s, es, m, r;
    int sh;
    for (int f = 0; f < 4; f++) begin
      v  = rand_word((f % 2 == 0) ? (1 << 19) : 300);
      m  = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      sh = int'($urandom_range(0, 31));
      clear_q();
      start_frame(v, m, sh, r);
      wait_frame(1'b1, ok);
      checks++; if (!ok || q_data.size() != NC) begin errors++; $display("FAIL rand frame %0d beats: got %0d want %0d", f, q_data.size(), NC); end
      es = 0;
      for (int c = 0; c < NC && c < q_data.size(); c++) begin
        checks++;
        exp = exp_core(v, c, m, sh, r, s); es |= s;
        if (q_data[c] !== exp || q_idx[c] !== c || q_last[c] !== (c == NC - 1)) begin
          errors++; $display("FAIL rand f%0d beat %0d (m=%0b sh=%0d r=%0b): got idx=%0d last=%0b data=%h want data=%h", f, c, m, sh, r, q_idx[c], q_last[c], q_data[c], exp);
        end
      end
      checks++; if (q_sat.size() != NC || q_sat[NC-1] !== es) begin errors++; $display("FAIL rand f%0d sat_flag: want %0b", f, es); end
    end
  endtask

  task automatic test_drop();
    word_t a, b;
    logic [DW-1:0] exp;
    bit ok, s;
    a = rand_word(1 << 12); b = rand_word(1 << 12);
    clear_q();
    start_frame(a, 1'b1, 6, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    drive_word(b); quant_mode = 1'b0; shift_amt = 5'd0; relu_en = 1'b1; infms_data_vld = 1'b1;
    @(posedge clk); #1;
    infms_data_vld = 1'b0;
    @(negedge clk);
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop drop_err: got %b want 1", drop_err); end
    wait_frame(1'b0, ok);
    checks++; if (!ok || q_data.size() != NC) begin errors++; $display("FAIL drop first frame beats: got %0d want %0d", q_data.size(), NC); end
    for (int c = 0; c < NC && c < q_data.size(); c++) begin
      checks++;
      exp = exp_core(a, c, 1'b1, 6, 1'b0, s);
      if (q_data[c] !== exp || q_idx[c] !== c) begin
        errors++; $display("FAIL drop frame A beat %0d: got idx=%0d data=%h want data=%h", c, q_idx[c], q_data[c], exp);
      end
    end
    clear_q();
    start_frame(b, 1'b0, 9, 1'b1);
    wait_frame(1'b0, ok);
    checks++; if (!ok || q_data.size() != NC) begin errors++; $display("FAIL drop next frame beats: got %0d want %0d", q_data.size(), NC); end
    for (int c = 0; c < NC && c < q_data.size(); c++) begin
      checks++;
      exp = exp_core(b, c, 1'b0, 9, 1'b1, s);
      if (q_data[c] !== exp || q_idx[c] !== c) begin
        errors++; $display("FAIL drop frame B beat %0d: got idx=%0d data=%h want data=%h", c, q_idx[c], q_data[c], exp);
      end
    end
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop sticky: got %b want 1", drop_err); end
  endtask

  task automatic test_rst_mid();
    word_t v;
    logic [DW-1:0] exp;
    bit ok, s, found;
    v = rand_word(1 << 15);
    clear_q(); found = 0;
    start_frame(v, 1'b1, 7, 1'b0);
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_vld && out_core_idx == 4'd7) begin rst = 1'b1; found = 1; end
      else begin @(posedge clk); #1; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst core7 never presented"); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_vld !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst mid: got vld=%b rdy=%b want vld=0 rdy=1", out_vld, in_ready); end
    checks++; if (drop_err !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rst mid flags: got drop=%b last=%b want 0 0", drop_err, out_last); end
    clear_q();
    v = rand_word(1 << 10);
    start_frame(v, 1'b0, 3, 1'b0);
    wait_frame(1'b0, ok);
    checks++; if (!ok || q_data.size() != NC) begin errors++; $display("FAIL rst new frame beats: got %0d want %0d", q_data.size(), NC); end
    for (int c = 0; c < NC && c < q_data.size(); c++) begin
      checks++;
      exp = exp_core(v, c, 1'b0, 3, 1'b0, s);
      if (q_data[c] !== exp || q_idx[c] !== c) begin
        errors++; $display("FAIL rst new frame beat %0d: got idx=%0d data=%h want data=%h", c, q_idx[c], q_data[c], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_int8_basic();
    test_int4_sat();
    test_rounding(1'b0);
    test_rounding(1'b1);
    test_backpressure();
    test_clk_en();
    test_random();
    test_drop();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
